// File: rtl/combat_referee.sv
// Two-player combat referee: hit detection, health, round timer and round-over handling.
// Build option: define REFEREE_AUTORESTART_EN to start a new round KO_FRAMES frames after one ends.
module combat_referee #(
    parameter int MAX_HEALTH     = 3,
    parameter int ROUND_SECONDS  = 60,
    parameter int FRAMES_PER_SEC = 60,
    parameter int KO_FRAMES      = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    input  logic [9:0] p1_hit_x1,
    input  logic [9:0] p1_hit_x2,
    input  logic [9:0] p1_hit_y1,
    input  logic [9:0] p1_hit_y2,
    input  logic [9:0] p2_hit_x1,
    input  logic [9:0] p2_hit_x2,
    input  logic [9:0] p2_hit_y1,
    input  logic [9:0] p2_hit_y2,
    input  logic [9:0] p1_hurt_x1,
    input  logic [9:0] p1_hurt_x2,
    input  logic [9:0] p1_hurt_y1,
    input  logic [9:0] p1_hurt_y2,
    input  logic [9:0] p2_hurt_x1,
    input  logic [9:0] p2_hurt_x2,
    input  logic [9:0] p2_hurt_y1,
    input  logic [9:0] p2_hurt_y2,
    output logic [2:0] p1_health,
    output logic [2:0] p2_health,
    output logic       p1_damaged,
    output logic       p2_damaged,
    output logic [6:0] seconds_left,
    output logic       freeze,
    output logic [1:0] winner
);

    // state | meaning
    // PLAY  | round running: hits, damage and timer advance on frame_tick
    // OVER  | round decided: everything frozen, winner valid

    localparam logic [0:0] ST_PLAY = 1'b0;
    localparam logic [0:0] ST_OVER = 1'b1;

    localparam logic [3:0] ATTACK_ACTIVE = 4'd4;

    localparam int FRAME_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);

    localparam logic [2:0] HEALTH_INIT  = 3'(MAX_HEALTH);
    localparam logic [6:0] SECONDS_INIT = 7'(ROUND_SECONDS);

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    logic [0:0]         state;
    logic [FRAME_W-1:0] frame_cnt;
    logic               p1_armed;
    logic               p2_armed;

    logic               hit_on_p1;
    logic               hit_on_p2;
    logic               p1_loses;
    logic               p2_loses;
    logic [2:0]         p1_health_nxt;
    logic [2:0]         p2_health_nxt;
    logic               frame_wrap;
    logic [6:0]         seconds_nxt;
    logic               round_end;
    logic               ko_restart;

    // Strict inequalities: rectangles that only share an edge do not overlap.
    function automatic logic rect_overlap(
        input logic [9:0] ax1, input logic [9:0] ax2,
        input logic [9:0] ay1, input logic [9:0] ay2,
        input logic [9:0] bx1, input logic [9:0] bx2,
        input logic [9:0] by1, input logic [9:0] by2
    );
        return (ax1 < bx2) && (bx1 < ax2) && (ay1 < by2) && (by1 < ay2);
    endfunction

    // Higher health wins; this also covers the case where exactly one player is at zero.
    function automatic logic [1:0] pick_winner(input logic [2:0] h1, input logic [2:0] h2);
        logic [1:0] w;
        if (h1 > h2)
            w = WIN_P1;
        else if (h2 > h1)
            w = WIN_P2;
        else
            w = WIN_DRAW;
        return w;
    endfunction

    always_comb begin
        hit_on_p2 = (p1_state == ATTACK_ACTIVE) && p1_armed &&
                    rect_overlap(p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
                                 p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2);
        hit_on_p1 = (p2_state == ATTACK_ACTIVE) && p2_armed &&
                    rect_overlap(p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
                                 p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2);

        p1_loses      = hit_on_p1 && (p1_health != 3'd0);
        p2_loses      = hit_on_p2 && (p2_health != 3'd0);
        p1_health_nxt = p1_loses ? (p1_health - 3'd1) : p1_health;
        p2_health_nxt = p2_loses ? (p2_health - 3'd1) : p2_health;

        frame_wrap  = (frame_cnt == FRAME_LAST);
        seconds_nxt = (frame_wrap && (seconds_left != 7'd0)) ? (seconds_left - 7'd1) : seconds_left;

        round_end = (p1_health_nxt == 3'd0) || (p2_health_nxt == 3'd0) || (seconds_nxt == 7'd0);
    end

`ifdef REFEREE_AUTORESTART_EN
    localparam int KO_W = (KO_FRAMES > 1) ? $clog2(KO_FRAMES) : 1;
    localparam logic [KO_W-1:0] KO_LAST = KO_W'(KO_FRAMES - 1);

    logic [KO_W-1:0] ko_cnt;

    assign ko_restart = frame_tick && (state == ST_OVER) && (ko_cnt == KO_LAST);

    always_ff @(posedge clk) begin
        if (rst || ko_restart)
            ko_cnt <= '0;
        else if (frame_tick && (state == ST_OVER))
            ko_cnt <= ko_cnt + KO_W'(1);
    end
`else
    assign ko_restart = 1'b0;
`endif

    // A KO-timeout restart reuses the reset values so a new round is indistinguishable from power-up.
    always_ff @(posedge clk) begin
        if (rst || ko_restart) begin
            state        <= ST_PLAY;
            p1_health    <= HEALTH_INIT;
            p2_health    <= HEALTH_INIT;
            p1_damaged   <= 1'b0;
            p2_damaged   <= 1'b0;
            seconds_left <= SECONDS_INIT;
            frame_cnt    <= '0;
            p1_armed     <= 1'b1;
            p2_armed     <= 1'b1;
            freeze       <= 1'b0;
            winner       <= WIN_NONE;
        end else begin
            p1_damaged <= 1'b0;
            p2_damaged <= 1'b0;
            if (frame_tick && (state == ST_PLAY)) begin
                p1_health  <= p1_health_nxt;
                p2_health  <= p2_health_nxt;
                p1_damaged <= p1_loses;
                p2_damaged <= p2_loses;

                // Armed re-arms only once the attacker leaves the active state: one attack, one hit.
                if (hit_on_p2)
                    p1_armed <= 1'b0;
                else if (p1_state != ATTACK_ACTIVE)
                    p1_armed <= 1'b1;
                if (hit_on_p1)
                    p2_armed <= 1'b0;
                else if (p2_state != ATTACK_ACTIVE)
                    p2_armed <= 1'b1;

                frame_cnt    <= frame_wrap ? '0 : (frame_cnt + FRAME_W'(1));
                seconds_left <= seconds_nxt;

                if (round_end) begin
                    state  <= ST_OVER;
                    freeze <= 1'b1;
                    winner <= pick_winner(p1_health_nxt, p2_health_nxt);
                end
            end
        end
    end

endmodule
